// File: rtl/servo_pkg.sv
// Shared defaults and FSM state type for the servo position sequencer.
package servo_pkg;

  localparam int SERVO_W          = 20;
  localparam int PERIOD_CYC_DEF   = 481001;
  localparam int MIN_W_DEF        = 11200;
  localparam int MID_W_DEF        = 40350;
  localparam int MAX_W_DEF        = 69500;
  localparam int STEP_DEF         = 1000;
  localparam int HOLD_FRAMES_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_HOLD = 2'd2
  } servo_state_t;

endpackage

// File: rtl/servo_pwm_gen.sv
// Frame counter, end-of-frame strobe, registered frame_start and registered PWM compare.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC = PERIOD_CYC_DEF,
  parameter int W          = SERVO_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cur_w,
  output logic         servo,
  output logic         frame_start,
  output logic         frame_end
);

  logic [W-1:0] cnt_r;
  logic         servo_r;
  logic         frame_start_r;

  assign frame_end   = (cnt_r == W'(PERIOD_CYC - 1));
  assign servo       = servo_r;
  assign frame_start = frame_start_r;

  // Free-running frame counter with registered pin and frame-start strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r         <= '0;
      servo_r       <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      cnt_r         <= frame_end ? '0 : cnt_r + W'(1);
      servo_r       <= (cnt_r < cur_w);
      frame_start_r <= (cnt_r == '0);
    end
  end

endmodule

// File: rtl/servo_seq_ctrl.sv
// Valid/ready position sequencer slewing one servo PWM pin toward a clamped target.
// Build option: define SERVO_SLEW_EN for bounded per-frame steps; otherwise the width jumps in one frame.
module servo_seq_ctrl
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC  = PERIOD_CYC_DEF,
  parameter int MIN_W       = MIN_W_DEF,
  parameter int MID_W       = MID_W_DEF,
  parameter int MAX_W       = MAX_W_DEF,
`ifdef SERVO_SLEW_EN
  parameter int STEP        = STEP_DEF,
`endif
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
  parameter int W           = SERVO_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_pos,
  output logic         busy,
  output logic         at_target,
  output logic         frame_start,
  output logic         servo
);

  servo_state_t state_r;
  logic [W-1:0] tgt_r;
  logic [W-1:0] cur_w_r;
  logic [W-1:0] hold_cnt_r;
  logic [W-1:0] clamp_s;
  logic         frame_end_s;

  assign cmd_ready = (state_r == ST_IDLE) && !rst;
  assign busy      = (state_r != ST_IDLE);
  assign at_target = (cur_w_r == tgt_r);

  // Saturate the requested width into the mechanically safe range.
  always_comb begin
    clamp_s = cmd_pos;
    if (cmd_pos < W'(MIN_W)) begin
      clamp_s = W'(MIN_W);
    end else if (cmd_pos > W'(MAX_W)) begin
      clamp_s = W'(MAX_W);
    end else begin
      clamp_s = cmd_pos;
    end
  end

`ifdef SERVO_SLEW_EN
  logic [W:0] diff_s;
  logic [W:0] mag_s;
  logic       near_s;

  // Signed distance to target; near_s means one step (or less) finishes the move.
  always_comb begin
    diff_s = {1'b0, tgt_r} - {1'b0, cur_w_r};
    if (diff_s[W]) begin
      mag_s = -diff_s;
    end else begin
      mag_s = diff_s;
    end
    near_s = (mag_s <= (W+1)'(STEP));
  end
`endif

  // Sequencer FSM; width changes only at the frame boundary so pulses never split.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tgt_r      <= W'(MID_W);
      cur_w_r    <= W'(MID_W);
      hold_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            tgt_r   <= clamp_s;
            state_r <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (frame_end_s) begin
`ifdef SERVO_SLEW_EN
            if (near_s) begin
              cur_w_r    <= tgt_r;
              state_r    <= ST_HOLD;
              hold_cnt_r <= '0;
            end else if (diff_s[W]) begin
              cur_w_r <= cur_w_r - W'(STEP);
            end else begin
              cur_w_r <= cur_w_r + W'(STEP);
            end
`else
            cur_w_r    <= tgt_r;
            state_r    <= ST_HOLD;
            hold_cnt_r <= '0;
`endif
          end
        end
        ST_HOLD: begin
          if (hold_cnt_r == W'(HOLD_FRAMES)) begin
            state_r <= ST_IDLE;
          end else if (frame_end_s) begin
            hold_cnt_r <= hold_cnt_r + W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  servo_pwm_gen #(
    .PERIOD_CYC (PERIOD_CYC),
    .W          (W)
  ) u_pwm (
    .clk         (clk),
    .rst         (rst),
    .cur_w       (cur_w_r),
    .servo       (servo),
    .frame_start (frame_start),
    .frame_end   (frame_end_s)
  );

endmodule

// File: tb/tb_servo_seq_ctrl.sv
// Self-checking bench for servo_seq_ctrl using short frames and a frame-level width model.
module tb_servo_seq_ctrl;

  localparam int P     = 200;
  localparam int MINW  = 20;
  localparam int MIDW  = 100;
  localparam int MAXW  = 180;
  localparam int STEPW = 15;
  localparam int HOLDF = 2;
  localparam int WW    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [WW-1:0] cmd_pos = '0;
  logic          cmd_ready, busy, at_target, frame_start, servo;

  int compared   = 0;
  int mismatched = 0;
  int t          = 0;     // cycles since reset; frame counter phase is t % P
  int mcur       = MIDW;  // model of the live width
  int held_t     = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) t <= rst ? 0 : t + 1;

  servo_seq_ctrl #(
    .PERIOD_CYC  (P),
    .MIN_W       (MINW),
    .MID_W       (MIDW),
    .MAX_W       (MAXW),
`ifdef SERVO_SLEW_EN
    .STEP        (STEPW),
`endif
    .HOLD_FRAMES (HOLDF),
    .W           (WW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_pos     (cmd_pos),
    .busy        (busy),
    .at_target   (at_target),
    .frame_start (frame_start),
    .servo       (servo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampm(input int v);
    if (v < MINW) return MINW;
    if (v > MAXW) return MAXW;
    return v;
  endfunction

  // Widths of successive frames while moving from 'from' to 'tgt'.
  task automatic build_list(input int from, input int tgt);
    int c;
    exp_q.delete();
    c = from;
`ifdef SERVO_SLEW_EN
    if (c == tgt) exp_q.push_back(c);
    while (c != tgt) begin
      if (tgt - c > STEPW)       c = c + STEPW;
      else if (c - tgt > STEPW)  c = c - STEPW;
      else                       c = tgt;
      exp_q.push_back(c);
    end
`else
    exp_q.push_back(tgt);
`endif
  endtask

  // Waits for frame_start, then counts servo-high cycles over one whole frame.
  task automatic measure(output int hi, output logic at, output int fcyc);
    int n;
    hi = 0;
    n  = 0;
    while (frame_start !== 1'b1 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    check("frame_start_seen", (n < 2 * P), 1);
    at   = at_target;
    fcyc = t;
    for (int i = 0; i < P; i++) begin
      if (servo === 1'b1) hi++;
      @(negedge clk);
    end
  endtask

  task automatic run_cmd(input int pos, input bit held, input bit at_bnd,
                         input bit chain, input int next_pos);
    int   tgt, tacc, hi, fcyc, n, w;
    logic at;
    tgt  = clampm(pos);
    fcyc = t;
    if (!held) begin
      if (at_bnd) begin
        n = 0;
        while ((t % P) != P - 1 && n <= P) begin
          @(negedge clk);
          n++;
        end
      end else begin
        repeat ($urandom_range(0, P - 1)) @(negedge clk);
      end
      check("ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_pos   = pos[WW-1:0];
      tacc      = t;
    end else begin
      tacc = held_t;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", cmd_ready, 0);
    @(negedge clk);
    build_list(mcur, tgt);
    if ((tacc % P) == P - 1) exp_q.push_front(mcur);
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      measure(hi, at, fcyc);
      check("frame_width", hi, w);
      check("at_target", at, (w == tgt));
    end
    mcur = tgt;
    if (chain) begin
      cmd_valid = 1'b1;
      cmd_pos   = next_pos[WW-1:0];
    end
    n = 0;
    while (busy === 1'b1 && n < 6 * P) begin
      @(negedge clk);
      n++;
    end
    check("hold_length", t - fcyc, HOLDF * P);
    check("ready_when_idle", cmd_ready, 1);
    held_t = t;
  endtask

  initial begin
    int   hi, fcyc, n, rtgt;
    logic at;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_servo", servo, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_busy", busy, 0);
    check("rst_ready_low", cmd_ready, 0);
    check("rst_at_target", at_target, 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    measure(hi, at, fcyc);
    check("idle_width", hi, MIDW);

    // full right, then a below-range command held valid while still busy
    run_cmd(MAXW, 1'b0, 1'b0, 1'b1, 5);
    run_cmd(5, 1'b1, 1'b0, 1'b0, 0);
    run_cmd(mcur, 1'b0, 1'b0, 1'b0, 0);
    run_cmd(250, 1'b0, 1'b1, 1'b0, 0);
    repeat (6) run_cmd($urandom_range(0, (1 << WW) - 1), 1'b0, 1'b0, 1'b0, 0);

    // reset in the middle of a pulse while moving
    rtgt = (mcur > MIDW) ? MINW : MAXW;
    repeat ($urandom_range(1, 20)) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_pos   = rtgt[WW-1:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_frame_seen", (n < 2 * P), 1);
    repeat (19) @(negedge clk);
    check("mid_pulse_servo_high", servo, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_servo", servo, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_frame_start", frame_start, 0);
    rst  = 1'b0;
    mcur = MIDW;
    @(negedge clk);
    measure(hi, at, fcyc);
    check("post_rst_width", hi, MIDW);
    check("post_rst_busy", busy, 0);
    check("post_rst_at_target", at, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
